// File: rtl/share_split_pkg.sv
// Shared masking definitions: splitter FSM states, default share geometry
// and the packed share-array typedef used by the splitter and its users.
package share_split_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    OUTPUT  = 2'd2
  } split_state_e;

  localparam int DEF_NUM_SHARES    = 3;
  localparam int DEF_ELEMENT_WIDTH = 8;

  // Element i of the packed array is share i; modules redeclare this
  // pattern locally with their own NUM_SHARES / ELEMENT_WIDTH.
  typedef logic [DEF_NUM_SHARES-1:0][DEF_ELEMENT_WIDTH-1:0] share_arr_t;

  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/reduce_xor.sv
// XOR-reduces a packed array of equal-width elements; used to recombine a
// Boolean sharing back into its unmasked value.
module reduce_xor #(
  parameter int NUM_ELEMENTS  = 2,
  parameter int ELEMENT_WIDTH = 8
) (
  input  logic [NUM_ELEMENTS*ELEMENT_WIDTH-1:0] elements,
  output logic [ELEMENT_WIDTH-1:0]              result
);

  always_comb begin
    // NOTE: combinational blocks use blocking '=' so the running XOR is
    // updated in order within one evaluation; a default first avoids latches.
    result = '0;
    for (int i = 0; i < NUM_ELEMENTS; i++) begin
      result = result ^ elements[i*ELEMENT_WIDTH +: ELEMENT_WIDTH];
    end
  end

endmodule

// File: rtl/share_split.sv
// Splits an unmasked value into NUM_SHARES Boolean shares: shares 0..N-2 are
// fresh RNG words, the last share is the value XORed with all of them.
module share_split
  import share_split_pkg::*;
#(
  parameter int NUM_SHARES    = DEF_NUM_SHARES,
  parameter int ELEMENT_WIDTH = DEF_ELEMENT_WIDTH
) (
  input  logic                                in_clk,
  input  logic                                in_rst_n,
  input  logic [ELEMENT_WIDTH-1:0]            in_value,
  input  logic                                in_valid,
  output logic                                out_ready,
  input  logic [ELEMENT_WIDTH-1:0]            in_rand,
  input  logic                                in_rand_valid,
  output logic                                out_rand_ready,
  output logic [NUM_SHARES*ELEMENT_WIDTH-1:0] out_shares,
  output logic                                out_valid,
  input  logic                                in_ready
);

  localparam int CNT_W = cnt_width(NUM_SHARES);
  localparam logic [CNT_W-1:0] LAST_K =
    (NUM_SHARES > 1) ? CNT_W'(NUM_SHARES - 2) : '0;
  localparam split_state_e LOAD_STATE = (NUM_SHARES > 1) ? COLLECT : OUTPUT;

  typedef logic [NUM_SHARES-1:0][ELEMENT_WIDTH-1:0] share_vec_t;

  split_state_e       state, state_next;
  logic [CNT_W-1:0]   cnt;
  logic [ELEMENT_WIDTH-1:0] acc;
  share_vec_t         share_q;
  share_vec_t         share_out;
  logic               in_xfer, rand_xfer, out_xfer, rand_last;

  // Handshakes and next state. out_ready is gated by reset so nothing is
  // offered upstream while the block is held in reset.
  always_comb begin
    out_valid      = (state == OUTPUT);
    out_rand_ready = (state == COLLECT);
    out_ready      = in_rst_n && ((state == IDLE) || ((state == OUTPUT) && in_ready));
    in_xfer        = in_valid && out_ready;
    rand_xfer      = in_rand_valid && out_rand_ready;
    out_xfer       = out_valid && in_ready;
    rand_last      = rand_xfer && (cnt == LAST_K);

    state_next = state;
    unique case (state)
      IDLE:    if (in_xfer)   state_next = LOAD_STATE;
      COLLECT: if (rand_last) state_next = OUTPUT;
      OUTPUT:  if (out_xfer)  state_next = in_xfer ? LOAD_STATE : IDLE;
      default:                state_next = IDLE;
    endcase
  end

  always_ff @(posedge in_clk or negedge in_rst_n) begin
    if (!in_rst_n) state <= IDLE;
    else           state <= state_next;
  end

  // In COLLECT and IDLE/OUTPUT the two transfer kinds are mutually exclusive,
  // so a new value load never races a random-word update.
  always_ff @(posedge in_clk or negedge in_rst_n) begin
    if (!in_rst_n) begin
      // NOTE: the share registers are reset like any other state because a
      // discarded sharing must never be visible on out_shares after reset.
      cnt     <= '0;
      acc     <= '0;
      share_q <= '0;
    end else if (in_xfer) begin
      // NOTE: sequential state uses non-blocking '<=' so every register
      // samples pre-edge values regardless of statement order.
      acc <= in_value;
      cnt <= '0;
    end else if (rand_xfer) begin
      acc <= acc ^ in_rand;
      cnt <= cnt + CNT_W'(1);
      for (int i = 0; i < NUM_SHARES - 1; i++) begin
        if (cnt == CNT_W'(i)) share_q[i] <= in_rand;
      end
    end
  end

  // The final share is the accumulator itself; no extra register needed.
  always_comb begin
    share_out                 = share_q;
    share_out[NUM_SHARES-1]   = acc;
  end

  assign out_shares = share_out;

endmodule
